e1_pingpong_ctrl: RTL
=====================

# e1_pingpong_ctrl

Ping-pong sequencer for the dual-bank E1 BRAM pair: a producer stream fills one bank while the consumer stream drains the other, and the roles swap per frame. It drives both banks' write ports (we/en/addr/din) and read ports (en/addr) and takes back both read-data buses. It sits between an upstream valid/ready source and a downstream valid/ready sink in the E1 stage. Its job is to make bank ownership, address counting and the 1-cycle BRAM read latency invisible to both sides.

## Interface
- BRAM_DATA_WIDTH, 64, word width
- BRAM_DEPTH, 64, words per bank
- BRAM_ADDR_WIDTH, clog2(BRAM_DEPTH), address width
- FRAME_LEN, BRAM_DEPTH, words per frame; legal range 2..BRAM_DEPTH
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid / s_ready  in / out  1 / 1  producer handshake
- s_data  in  BRAM_DATA_WIDTH  producer word
- m_valid / m_ready  out / in  1 / 1  consumer handshake
- m_data  out  BRAM_DATA_WIDTH  consumer word
- m_last  out  1  marks word FRAME_LEN-1 of a frame
- bram{0,1}_wr_en, bram{0,1}_we  out  1  write-port enable and write strobe, always driven equal
- bram{0,1}_wr_addr, bram{0,1}_rd_addr  out  BRAM_ADDR_WIDTH  bank addresses
- bram{0,1}_din  out  BRAM_DATA_WIDTH  write data (= s_data)
- bram{0,1}_rd_en  out  1  read enable
- bram{0,1}_dout  in  BRAM_DATA_WIDTH  read data, valid the cycle after rd_en
- bank_full  out  2  per-bank full flag, for status/debug

## Operation
- State: wr_bank, rd_bank (1 bit each), wr_ptr, rd_ptr (BRAM_ADDR_WIDTH), full[1:0], inflight (1 bit), 2-entry output FIFO.
- Write side:
  - s_ready = !full[wr_bank].
  - On an s_valid & s_ready cycle: drive bram[wr_bank] wr_en = we = 1, wr_addr = wr_ptr, din = s_data, and increment wr_ptr.
  - When wr_ptr == FRAME_LEN-1 on accept: set full[wr_bank], clear wr_ptr, toggle wr_bank.
- Read side:
  - Issue condition: full[rd_bank] && (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready.
  - On issue: drive bram[rd_bank] rd_en = 1, rd_addr = rd_ptr, set inflight, and tag the word last if rd_ptr == FRAME_LEN-1.
  - Last issue: clear full[rd_bank], clear rd_ptr, toggle rd_bank.
  - Next cycle: bram[issuing bank]_dout and its last tag are pushed into the FIFO; inflight clears unless a new read was issued that cycle.
- Output: m_valid = FIFO non-empty; m_data and m_last come from the FIFO head.
- Unused ports of the idle bank are held at 0 (en/we/addr/din).
- Ordering: frames are delivered in fill order. Bank 0 is filled first after reset.
- Simultaneous events:
  - The writer can only set full on a bank with full = 0, and the reader can only clear it on a bank with full = 1, so set and clear never hit the same bank.
  - Write to bank b at address 0 in the cycle after b's last read issue is legal, because the BRAM registered that read at the prior edge.
- Reset mid-operation: all state clears immediately and partial frames are discarded. BRAM contents are not touched.

## Timing
- Reset values:
  - s_ready = 1, m_valid = 0, m_last = 0, m_data = 0.
  - All BRAM enables, addresses and din = 0; bank_full = 2'b00.
  - wr_bank = rd_bank = 0.
- Write latency: a word accepted at edge E is written to the BRAM at edge E.
- First-word latency: m_valid rises 2 edges after the edge accepting a frame's last word, provided the read side is idle.
- Throughput: 1 word/cycle each side, sustained, with continuous s_valid and m_ready. Two full frames can be buffered.
- Stall: with m_ready = 0, at most 2 reads are outstanding. m_data and m_last are held stable while m_valid & !m_ready.
- Back-pressure: s_ready drops the cycle after both banks become full, and rises the cycle after the first bank's last read issue.

## Structure
- Shared package e1_pkg holds:
  - clog2 function
  - bank_sel_t (1-bit) typedef
  - e1_word_t typedef sized by BRAM_DATA_WIDTH
- Sub-module e1_out_fifo2: a 2-entry FIFO of {last, data} with push/pop/count, async active-low reset.
- Top-level instance of e1_pingpong_ctrl sits beside E1_bram_wr_rd; its ports map 1:1 onto the bram0_*/bram1_* pins.

## Test plan
All scenarios use DEPTH = 64, FRAME_LEN = 4.
- Reset then push words 1..4 with m_ready = 1: bram0 writes at addresses 0..3; m_data = 1,2,3,4 with m_last on 4; first m_valid 2 edges after the 4th accept.
- Continuous 3 frames (1..12), s_valid = m_ready = 1: banks alternate 0,1,0; output is 1..12 with no bubbles after the first; m_last on 4, 8, 12.
- m_ready = 0 while pushing 9 words: s_ready drops after word 8, bank_full = 2'b11, and word 9 is held. Raising m_ready then drains 1..8 and accepts 9.
- m_ready toggling 1010...: no duplicate or lost words; m_data stable whenever m_valid & !m_ready.
- Assert rst_n low mid-frame (after word 2 of frame 2): all outputs return to reset values asynchronously. A new frame 100..103 then comes out in order from bank 0.
- FRAME_LEN = BRAM_DEPTH: addresses 0..63 are exercised; wr_ptr and rd_ptr wrap to 0 with no address 64 ever driven.

Source files
------------

// File: rtl/e1_pkg.sv
// Shared types and helpers for the E1 ping-pong BRAM stage.
package e1_pkg;

  localparam int E1_WORD_W = 64;

  typedef logic bank_sel_t;
  typedef logic [E1_WORD_W-1:0] e1_word_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/e1_out_fifo2.sv
// Two-entry {last, data} FIFO that absorbs the BRAM read latency on the consumer side.
module e1_out_fifo2
  import e1_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_last_o,
  output logic [1:0]        count_o
);

  logic [DATA_W:0] mem_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      count_q;
  logic [1:0]      count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign {head_last_o, head_data_o} = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/e1_pingpong_ctrl.sv
// Ping-pong sequencer: the producer fills one BRAM bank while the consumer drains
// the other; bank ownership and the 1-cycle read latency stay hidden from both sides.
module e1_pingpong_ctrl
  import e1_pkg::*;
#(
  parameter int BRAM_DATA_WIDTH = 64,
  parameter int BRAM_DEPTH      = 64,
  parameter int BRAM_ADDR_WIDTH = clog2(BRAM_DEPTH),
  parameter int FRAME_LEN       = BRAM_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [BRAM_DATA_WIDTH-1:0] s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [BRAM_DATA_WIDTH-1:0] m_data,
  output logic                       m_last,
  output logic                       bram0_wr_en,
  output logic                       bram0_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram0_wr_addr,
  output logic [BRAM_DATA_WIDTH-1:0] bram0_din,
  output logic                       bram0_rd_en,
  output logic [BRAM_ADDR_WIDTH-1:0] bram0_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram0_dout,
  output logic                       bram1_wr_en,
  output logic                       bram1_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram1_wr_addr,
  output logic [BRAM_DATA_WIDTH-1:0] bram1_din,
  output logic                       bram1_rd_en,
  output logic [BRAM_ADDR_WIDTH-1:0] bram1_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram1_dout,
  output logic [1:0]                 bank_full
);

  localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR = BRAM_ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE  = BRAM_ADDR_WIDTH'(1);

  bank_sel_t                  wr_bank_q, wr_bank_d;
  bank_sel_t                  rd_bank_q, rd_bank_d;
  bank_sel_t                  iss_bank_q;
  logic [BRAM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [BRAM_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]                 full_q, full_d;
  logic                       inflight_q;
  logic                       iss_last_q;

  logic                       accept;
  logic                       issue;
  logic                       pop;
  logic                       wr_last;
  logic                       rd_last;
  logic [1:0]                 fifo_count;
  logic [2:0]                 occ;
  logic                       wr_sel0, wr_sel1, rd_sel0, rd_sel1;

  assign s_ready = !full_q[wr_bank_q];
  assign accept  = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  assign wr_last = (wr_ptr_q == LAST_ADDR);
  assign rd_last = (rd_ptr_q == LAST_ADDR);

  // Occupancy seen by the next issue: words held, plus one in flight, minus this cycle's pop.
  assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = full_q[rd_bank_q] && (occ < 3'd2);

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    full_d    = full_q;
    if (accept) begin
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_ptr_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_ONE;
      end
    end
    if (issue) begin
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_ptr_d          = '0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_ptr_d = rd_ptr_q + ADDR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 2'b00;
      inflight_q <= 1'b0;
      iss_bank_q <= 1'b0;
      iss_last_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      inflight_q <= issue;
      if (issue) begin
        iss_bank_q <= rd_bank_q;
        iss_last_q <= rd_last;
      end
    end
  end

  // Bank port steering; the idle bank's pins stay at zero.
  assign wr_sel0 = accept & (wr_bank_q == 1'b0);
  assign wr_sel1 = accept & (wr_bank_q == 1'b1);
  assign rd_sel0 = issue  & (rd_bank_q == 1'b0);
  assign rd_sel1 = issue  & (rd_bank_q == 1'b1);

  assign bram0_wr_en   = wr_sel0;
  assign bram0_we      = wr_sel0;
  assign bram0_wr_addr = wr_sel0 ? wr_ptr_q : '0;
  assign bram0_din     = wr_sel0 ? s_data : '0;
  assign bram0_rd_en   = rd_sel0;
  assign bram0_rd_addr = rd_sel0 ? rd_ptr_q : '0;

  assign bram1_wr_en   = wr_sel1;
  assign bram1_we      = wr_sel1;
  assign bram1_wr_addr = wr_sel1 ? wr_ptr_q : '0;
  assign bram1_din     = wr_sel1 ? s_data : '0;
  assign bram1_rd_en   = rd_sel1;
  assign bram1_rd_addr = rd_sel1 ? rd_ptr_q : '0;

  assign bank_full = full_q;

  e1_out_fifo2 #(
    .DATA_W (BRAM_DATA_WIDTH)
  ) u_out_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (inflight_q),
    .push_data_i (iss_bank_q ? bram1_dout : bram0_dout),
    .push_last_i (iss_last_q),
    .pop_i       (pop),
    .head_data_o (m_data),
    .head_last_o (m_last),
    .count_o     (fifo_count)
  );

  assign m_valid = (fifo_count != 2'd0);

endmodule
